// File: rtl/i2c_reg_slave.sv
// i2c_reg_slave -- I2C target exposing a simple 8-bit register map.
//
// Bus protocol: START, 7-bit device address + R/W, then either
//   write: register pointer byte, then data bytes (each ACKed, one reg_we each)
//   read : data bytes from the pointer, master ACK continues, NACK ends.
// The pointer auto-increments after every data byte and persists across
// transactions. SCL is never stretched.
//
// Optional feature macro: I2C_SPIKE_FILTER_EN
//   defined   : synchronized SCL/SDA must hold a new level for FILT_LEN
//               consecutive clk samples before it is accepted.
//   undefined : synchronizer outputs are used directly.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   scl        I2C clock from the bus (asynchronous)
//   sda_in     I2C data as seen on the pad (asynchronous)
//   sda_oe     1 = pull SDA low, 0 = release
//   reg_addr   register pointer
//   reg_wdata  write data, valid with reg_we
//   reg_we     one-cycle write strobe
//   reg_re     one-cycle read strobe, reg_rdata sampled the cycle after
//   reg_rdata  read data from the register map
module i2c_reg_slave #(
   parameter logic [6:0] SLAVE_ID = 7'h24,
   parameter int         FILT_LEN = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scl,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_we,
   output logic       reg_re,
   input  logic [7:0] reg_rdata
);

   typedef enum logic [3:0] {
      IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK,
      WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
   } state_t;

   // ---------------------------------------------------------------
   // Input conditioning. Bit 1 carries SCL, bit 0 carries SDA.
   // ---------------------------------------------------------------
   logic [1:0] sync1_q, sync2_q;
   logic [1:0] lvl;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 2'b11;
         sync2_q <= 2'b11;
      end else begin
         sync1_q <= {scl, sda_in};
         sync2_q <= sync1_q;
      end
   end

`ifdef I2C_SPIKE_FILTER_EN
   localparam int FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN + 1) : 1;
   logic [1:0]          flt_q;
   logic [1:0][FCW-1:0] fcnt_q;

   // Count consecutive samples that differ from the accepted level; any
   // sample agreeing with it restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flt_q  <= 2'b11;
         fcnt_q <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == flt_q[i]) begin
               fcnt_q[i] <= '0;
            end else if (fcnt_q[i] == FCW'(FILT_LEN - 1)) begin
               flt_q[i]  <= sync2_q[i];
               fcnt_q[i] <= '0;
            end else begin
               fcnt_q[i] <= fcnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign lvl = flt_q;
`else
   assign lvl = sync2_q;
`endif

   // Edge detection stays blind until the conditioned levels reflect the
   // real bus; otherwise a reset released while SDA is held low with SCL
   // high would look like a START. Long enough for either build.
   localparam int PRIME = FILT_LEN + 3;
   logic [7:0] prime_q;
   logic       primed;
   logic [1:0] lvl_p_q;

   assign primed = (prime_q == 8'(PRIME));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prime_q <= '0;
         lvl_p_q <= 2'b11;
      end else begin
         if (!primed) prime_q <= prime_q + 8'd1;
         lvl_p_q <= lvl;
      end
   end

   logic scl_f, sda_f, scl_p, sda_p;
   logic scl_rise, scl_fall, start_det, stop_det;

   assign scl_f     = lvl[1];
   assign sda_f     = lvl[0];
   assign scl_p     = lvl_p_q[1];
   assign sda_p     = lvl_p_q[0];
   assign scl_rise  = primed &  scl_f & ~scl_p;
   assign scl_fall  = primed & ~scl_f &  scl_p;
   assign start_det = primed & scl_f & scl_p &  sda_p & ~sda_f;
   assign stop_det  = primed & scl_f & scl_p & ~sda_p &  sda_f;

   // ---------------------------------------------------------------
   // Protocol FSM
   // ---------------------------------------------------------------
   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] sh_q, sh_d;
   logic [7:0] tx_q, tx_d;
   logic       rw_q, rw_d;
   logic       mack_q, mack_d;
   logic       sda_oe_q, sda_oe_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic       we_q, we_d;
   logic       re_q, re_d;
   logic       ld_q, ld_d;
   logic       byte_done;

   assign byte_done = scl_fall && (cnt_q == 4'd8);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         sh_q     <= '0;
         tx_q     <= '0;
         rw_q     <= 1'b0;
         mack_q   <= 1'b0;
         sda_oe_q <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         re_q     <= 1'b0;
         ld_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sh_q     <= sh_d;
         tx_q     <= tx_d;
         rw_q     <= rw_d;
         mack_q   <= mack_d;
         sda_oe_q <= sda_oe_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
         re_q     <= re_d;
         ld_q     <= ld_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sh_d     = sh_q;
      tx_d     = tx_q;
      rw_d     = rw_q;
      mack_d   = mack_q;
      sda_oe_d = sda_oe_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      we_d     = 1'b0;
      re_d     = 1'b0;
      ld_d     = re_q;

      // Pointer advances the cycle after each write strobe.
      if (we_q) addr_d = addr_q + 8'd1;

      // Read data arrives the cycle after reg_re. When the load follows a
      // master ACK we are already in RD_DATA with SCL low, so the first bit
      // goes straight onto the bus; after DEV_ACK it waits for SCL fall.
      if (ld_q) begin
         tx_d = reg_rdata;
         if (state_q == RD_DATA) begin
            sda_oe_d = ~reg_rdata[7];
            tx_d     = {reg_rdata[6:0], 1'b0};
         end
      end

      if (stop_det) begin
         state_d  = IDLE;
         cnt_d    = '0;
         sda_oe_d = 1'b0;
      end else if (start_det) begin
         state_d  = DEV_ADDR;
         cnt_d    = '0;
         sda_oe_d = 1'b0;
      end else begin
         if (scl_rise && (state_q inside {DEV_ADDR, REG_ADDR, WR_DATA, RD_DATA}))
            cnt_d = cnt_q + 4'd1;
         if (scl_rise && (state_q inside {DEV_ADDR, REG_ADDR, WR_DATA}))
            sh_d = {sh_q[6:0], sda_f};

         case (state_q)
            DEV_ADDR: if (byte_done) begin
               cnt_d = '0;
               if (sh_q[7:1] == SLAVE_ID) begin
                  state_d  = DEV_ACK;
                  sda_oe_d = 1'b1;
                  rw_d     = sh_q[0];
                  re_d     = sh_q[0];
               end else begin
                  state_d = IGNORE;
               end
            end
            DEV_ACK: if (scl_fall) begin
               if (rw_q) begin
                  state_d  = RD_DATA;
                  sda_oe_d = ~tx_q[7];
                  tx_d     = {tx_q[6:0], 1'b0};
               end else begin
                  state_d  = REG_ADDR;
                  sda_oe_d = 1'b0;
               end
            end
            REG_ADDR: if (byte_done) begin
               cnt_d    = '0;
               addr_d   = sh_q;
               state_d  = REG_ACK;
               sda_oe_d = 1'b1;
            end
            REG_ACK: if (scl_fall) begin
               state_d  = WR_DATA;
               sda_oe_d = 1'b0;
            end
            WR_DATA: if (byte_done) begin
               cnt_d    = '0;
               we_d     = 1'b1;
               wdata_d  = sh_q;
               state_d  = WR_ACK;
               sda_oe_d = 1'b1;
            end
            WR_ACK: if (scl_fall) begin
               state_d  = WR_DATA;
               sda_oe_d = 1'b0;
            end
            RD_DATA: if (scl_fall) begin
               if (cnt_q == 4'd8) begin
                  cnt_d    = '0;
                  state_d  = RD_ACK;
                  sda_oe_d = 1'b0;
               end else begin
                  sda_oe_d = ~tx_q[7];
                  tx_d     = {tx_q[6:0], 1'b0};
               end
            end
            RD_ACK: begin
               if (scl_rise) mack_d = sda_f;
               // Every byte sent consumes its address, so the pointer
               // ends one past the last byte read.
               if (scl_fall) begin
                  addr_d = addr_q + 8'd1;
                  if (!mack_q) begin
                     state_d = RD_DATA;
                     re_d    = 1'b1;
                  end else begin
                     state_d = IGNORE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign sda_oe    = sda_oe_q;
   assign reg_addr  = addr_q;
   assign reg_wdata = wdata_q;
   assign reg_we    = we_q;
   assign reg_re    = re_q;

endmodule

// File: doc/i2c_reg_slave.md
I2C_REG_SLAVE -- requirements
Module: i2c_reg_slave

Interface
REQ-001 SHALL have parameter SLAVE_ID, default 7'h24, 7-bit device address matched after START.
REQ-002 SHALL have parameter FILT_LEN, default 3, number of consecutive equal synchronized samples required to accept a new SCL/SDA level.
REQ-003 SHALL have port clk  input  1  system clock (10 MHz nominal), all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port scl  input  1  I2C clock from the bus, asynchronous to clk.
REQ-006 SHALL have port sda_in  input  1  I2C data as read from the bus pad, asynchronous to clk.
REQ-007 SHALL have port sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
REQ-008 SHALL have port reg_addr  output  8  current register address pointer.
REQ-009 SHALL have port reg_wdata  output  8  write data, valid while reg_we=1.
REQ-010 SHALL have port reg_we  output  1  one-cycle register write strobe.
REQ-011 SHALL have port reg_re  output  1  one-cycle register read strobe; reg_rdata sampled on the following cycle.
REQ-012 SHALL have port reg_rdata  input  8  read data from register map.

Function
REQ-013 SHALL pass scl and sda_in through 2-flop synchronizers before any use.
REQ-014 SHALL detect START as filtered SDA falling while filtered SCL high, STOP as SDA rising while SCL high; bit sampling on filtered SCL rising edge, SDA updates on filtered SCL falling edge.
REQ-015 SHALL implement states IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE; STOP from any state -> IDLE; START (incl. repeated) from any state -> DEV_ADDR with bit counter cleared.
REQ-016 SHALL shift 8 bits MSB first in DEV_ADDR; on [7:1]==SLAVE_ID assert sda_oe for the ACK bit (DEV_ACK), else release SDA and go to IGNORE until START/STOP.
REQ-017 SHALL, after addressed write (R/W=0), receive one byte into reg_addr in REG_ADDR, ACK it, then receive data bytes in WR_DATA, ACKing each.
REQ-018 SHALL pulse reg_we for exactly one clk on the SCL falling edge ending the 8th data bit, with reg_wdata=received byte and reg_addr=pointer; reg_addr SHALL increment one clk after the strobe.
REQ-019 SHALL, after addressed read (R/W=1), pulse reg_re at DEV_ACK entry, load reg_rdata into the transmit shifter one clk later, and drive bits MSB first in RD_DATA (sda_oe = ~bit).
REQ-020 SHALL release SDA in RD_ACK and sample master ACK; ACK (0) -> increment reg_addr, pulse reg_re, reload, continue RD_DATA; NACK (1) -> IGNORE.
REQ-021 SHALL wrap reg_addr 8'hFF -> 8'h00 on increment; reg_addr SHALL persist across transactions so a read without register phase starts at last pointer.
REQ-022 SHALL never assert sda_oe while SCL high except while holding an ACK/data bit driven since the previous SCL fall; SHALL NOT stretch SCL.
REQ-023 SHALL ignore data bytes after STOP mid-byte (partial byte discarded, no reg_we).

Reset
REQ-024 SHALL on rst_n=0 immediately set state IDLE, sda_oe=0, reg_we=0, reg_re=0, reg_addr=8'h00, reg_wdata=8'h00, shifters/counters 0, synchronizer and filter outputs 1 (bus idle).
REQ-025 SHALL, after reset release mid-transaction, ignore bus activity until the next START.

Configuration
REQ-026 SHALL, with macro I2C_SPIKE_FILTER_EN defined, apply the FILT_LEN consecutive-sample filter to synchronized SCL and SDA; without it, synchronizer outputs SHALL be used directly (filter latency 0, FILT_LEN unused).

Verification
REQ-027 SHALL cover: write 0x24/W, reg 0x00, data 0xF0,0x00 at 400 kHz -> ACK on all 4 bytes, reg_we pulses with (addr 0x00, 0xF0) then (0x01, 0x00).
REQ-028 SHALL cover: write reg 0x00, repeated START, 0x24/R, read 2 bytes (ACK, NACK) with map returning 0xF0,0x00 -> SDA shows 0xF0 then 0x00, two reg_re pulses, reg_addr ends 0x02.
REQ-029 SHALL cover: address 0x25/W -> no ACK (SDA high on 9th clock), no reg_we/reg_re until next START.
REQ-030 SHALL cover: write reg 0xFF, data 0x11,0x22 -> reg_we at 0xFF then 0x00.
REQ-031 SHALL cover: rst_n low for 1 clk during 5th data bit -> sda_oe=0 immediately, no reg_we, next transaction to 0x24 ACKed normally.
REQ-032 SHALL cover, with I2C_SPIKE_FILTER_EN: 1-clk low glitch on SCL while high -> no bit shifted, transaction completes with correct data.
